// File: rtl/health_controller.sv
// Per-player health keeper: block reduction, iframes, combo tracking, KO detection.
// Latency: a hit sampled at edge N is reflected on every output right after edge N.
// Backpressure: none; hits arriving during iframes or KO are dropped, never queued.
module health_controller #(
  parameter int FULL_HEALTH   = 200,
  parameter int IFRAME_CYCLES = 25_000_000,
  parameter int COMBO_WINDOW  = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       hit_valid,
  input  logic [7:0] hit_damage,
  input  logic       blocking,
  output logic       hit_ack,
  output logic [8:0] curr_health,
  output logic       stunned,
  output logic       ko,
  output logic       is_ko,
  output logic [3:0] combo_count
);

  localparam int IW = (IFRAME_CYCLES > 1) ? $clog2(IFRAME_CYCLES + 1) : 1;
  localparam int CW = $clog2(COMBO_WINDOW + 1);
  localparam logic [8:0]    FULL        = 9'(FULL_HEALTH);
  localparam logic [IW-1:0] IFRAME_LOAD = IW'(IFRAME_CYCLES - 1);
  localparam logic [CW-1:0] COMBO_LOAD  = CW'(COMBO_WINDOW);

  typedef enum logic [1:0] {ALIVE, INVULN, KO} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] iframe_cnt, iframe_nxt;
  logic [CW-1:0] combo_tmr, combo_tmr_nxt;
  logic [3:0]    combo_nxt;
  logic [8:0]    health_nxt;
  logic          ack_nxt;
  logic          ko_nxt;

  logic [8:0]    eff;
  logic [8:0]    health_after;
  logic          accept;

  // Blocked hits lose their two low bits; saturate before subtracting so 9-bit math never wraps.
  assign eff          = blocking ? {3'b000, hit_damage[7:2]} : {1'b0, hit_damage};
  assign health_after = (eff >= curr_health) ? 9'd0 : (curr_health - eff);

  // The last iframe cycle (counter at 0) already accepts a new hit, so held hits land
  // exactly IFRAME_CYCLES apart.
  assign accept = hit_valid &&
                  ((state == ALIVE) || ((state == INVULN) && (iframe_cnt == '0)));

  // Next-state and next-output computation; an accepted hit overrides timer housekeeping.
  always_comb begin
    state_nxt     = state;
    iframe_nxt    = iframe_cnt;
    combo_tmr_nxt = combo_tmr;
    combo_nxt     = combo_count;
    health_nxt    = curr_health;
    ack_nxt       = 1'b0;
    ko_nxt        = 1'b0;

    // Combo timer free-runs down; expiry clears the combo except in KO, where it is frozen.
    if (combo_tmr != '0) begin
      combo_tmr_nxt = combo_tmr - CW'(1);
      if ((combo_tmr == CW'(1)) && (state != KO)) begin
        combo_nxt = 4'd0;
      end
    end

    case (state)
      INVULN: begin
        if (iframe_cnt != '0) begin
          iframe_nxt = iframe_cnt - IW'(1);
        end else begin
          state_nxt = ALIVE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      ack_nxt       = 1'b1;
      health_nxt    = health_after;
      combo_tmr_nxt = COMBO_LOAD;
      if (combo_tmr != '0) begin
        combo_nxt = (combo_count == 4'd15) ? 4'd15 : (combo_count + 4'd1);
      end else begin
        combo_nxt = 4'd1;
      end
      if (health_after == 9'd0) begin
        state_nxt  = KO;
        ko_nxt     = 1'b1;
        iframe_nxt = '0;
      end else begin
        state_nxt  = INVULN;
        iframe_nxt = IFRAME_LOAD;
      end
    end
  end

  // State and output registers; round_start behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || round_start) begin
      state       <= ALIVE;
      iframe_cnt  <= '0;
      combo_tmr   <= '0;
      combo_count <= 4'd0;
      curr_health <= FULL;
      hit_ack     <= 1'b0;
      ko          <= 1'b0;
      stunned     <= 1'b0;
      is_ko       <= 1'b0;
    end else begin
      state       <= state_nxt;
      iframe_cnt  <= iframe_nxt;
      combo_tmr   <= combo_tmr_nxt;
      combo_count <= combo_nxt;
      curr_health <= health_nxt;
      hit_ack     <= ack_nxt;
      ko          <= ko_nxt;
      stunned     <= (state_nxt == INVULN);
      is_ko       <= (state_nxt == KO);
    end
  end

endmodule

// File: tb/tb_health_controller.sv
// Bench for health_controller with short iframe and combo windows.
// Reference model tracks hit timestamps rather than counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_health_controller;

  localparam int FULL = 200;
  localparam int IF   = 8;
  localparam int CWIN = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       round_start = 1'b0;
  logic       hit_valid = 1'b0;
  logic [7:0] hit_damage = 8'd0;
  logic       blocking = 1'b0;
  logic       hit_ack;
  logic [8:0] curr_health;
  logic       stunned;
  logic       ko;
  logic       is_ko;
  logic [3:0] combo_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_e = 0;
  int m_last = 0;
  bit m_has = 0;
  int m_health = FULL;
  bit m_ko = 0;
  int m_combo = 0;
  bit m_ack = 0;
  bit m_kop = 0;

  health_controller #(.FULL_HEALTH(FULL), .IFRAME_CYCLES(IF), .COMBO_WINDOW(CWIN)) dut (
    .clk(clk), .reset(reset), .round_start(round_start), .hit_valid(hit_valid),
    .hit_damage(hit_damage), .blocking(blocking), .hit_ack(hit_ack),
    .curr_health(curr_health), .stunned(stunned), .ko(ko), .is_ko(is_ko),
    .combo_count(combo_count)
  );

  always #5 clk = ~clk;

  function automatic bit exp_stun();
    return m_has && !m_ko && (m_e < m_last + IF);
  endfunction

  function automatic int exp_combo();
    if (!m_ko && m_has && (m_e - m_last >= CWIN)) return 0;
    return m_combo;
  endfunction

  // Drive one cycle of inputs and advance the model across the edge.
  task automatic tick(input bit hv, input int dmg, input bit blk, input bit rs, input bit rst);
    int eff;
    bit running;
    hit_valid   = hv;
    hit_damage  = dmg[7:0];
    blocking    = blk;
    round_start = rs;
    reset       = rst;
    @(posedge clk);
    m_e++;
    m_ack = 0;
    m_kop = 0;
    if (rs || rst) begin
      m_health = FULL; m_ko = 0; m_has = 0; m_combo = 0;
    end else if (hv && !m_ko && (!m_has || m_e >= m_last + IF)) begin
      eff = blk ? (dmg & 255) / 4 : (dmg & 255);
      running = m_has && (m_e - m_last <= CWIN);
      m_combo = running ? ((m_combo + 1 > 15) ? 15 : m_combo + 1) : 1;
      m_health = (eff >= m_health) ? 0 : m_health - eff;
      m_last = m_e; m_has = 1; m_ack = 1;
      if (m_health == 0) begin m_ko = 1; m_kop = 1; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    n_vec++; if (curr_health !== 9'd200) begin n_err++; $display("FAIL reset_health got=%0d exp=200", curr_health); end
    n_vec++; if ({hit_ack, stunned, ko, is_ko} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {hit_ack, stunned, ko, is_ko}); end
    n_vec++; if (combo_count !== 4'd0) begin n_err++; $display("FAIL reset_combo got=%0d exp=0", combo_count); end
  endtask

  task automatic test_basic_hit();
    int stun_len;
    tick(1, 30, 0, 0, 0);
    n_vec++; if (hit_ack !== 1'b1) begin n_err++; $display("FAIL basic_ack got=%b exp=1", hit_ack); end
    n_vec++; if (curr_health !== 9'd170) begin n_err++; $display("FAIL basic_health got=%0d exp=170", curr_health); end
    n_vec++; if (combo_count !== 4'd1) begin n_err++; $display("FAIL basic_combo got=%0d exp=1", combo_count); end
    stun_len = stunned ? 1 : 0;
    tick(0, 0, 0, 0, 0);
    n_vec++; if (hit_ack !== 1'b0) begin n_err++; $display("FAIL basic_ack_pulse got=%b exp=0", hit_ack); end
    if (stunned) stun_len++;
    for (int k = 0; k < 50 && stunned; k++) begin
      tick(0, 0, 0, 0, 0);
      if (stunned) stun_len++;
    end
    n_vec++; if (stun_len != IF) begin n_err++; $display("FAIL basic_stun_len got=%0d exp=%0d", stun_len, IF); end
  endtask

  task automatic test_blocked();
    tick(1, 30, 1, 0, 0);
    n_vec++; if (curr_health !== 9'd163) begin n_err++; $display("FAIL blocked_health got=%0d exp=163", curr_health); end
    idle(IF);
    tick(1, 3, 1, 0, 0);
    n_vec++; if (hit_ack !== 1'b1) begin n_err++; $display("FAIL blocked0_ack got=%b exp=1", hit_ack); end
    n_vec++; if (curr_health !== 9'd163) begin n_err++; $display("FAIL blocked0_health got=%0d exp=163", curr_health); end
    n_vec++; if (stunned !== 1'b1) begin n_err++; $display("FAIL blocked0_stun got=%b exp=1", stunned); end
    n_vec++; if (combo_count !== 4'(m_combo)) begin n_err++; $display("FAIL blocked0_combo got=%0d exp=%0d", combo_count, m_combo); end
    tick(1, 50, 0, 0, 0);
    n_vec++; if (hit_ack !== 1'b0 || curr_health !== 9'd163) begin n_err++; $display("FAIL invuln_ignore ack=%b health=%0d exp ack=0 health=163", hit_ack, curr_health); end
  endtask

  task automatic test_invuln_hold();
    int acks = 0;
    idle(30);
    for (int i = 0; i < 40; i++) begin
      tick(1, 1, 0, 0, 0);
      if (hit_ack) acks++;
      n_vec++; if (hit_ack !== ((i % IF) == 0)) begin n_err++; $display("FAIL hold_ack cyc=%0d got=%b exp=%b", i, hit_ack, (i % IF) == 0); end
    end
    n_vec++; if (acks != 5) begin n_err++; $display("FAIL hold_acks got=%0d exp=5", acks); end
    n_vec++; if (combo_count !== 4'd5) begin n_err++; $display("FAIL hold_combo got=%0d exp=5", combo_count); end
    n_vec++; if (curr_health !== 9'(m_health)) begin n_err++; $display("FAIL hold_health got=%0d exp=%0d", curr_health, m_health); end
  endtask

  task automatic test_combo_spacing();
    idle(30);
    for (int h = 0; h < 3; h++) begin
      tick(1, 2, 0, 0, 0);
      n_vec++; if (combo_count !== 4'd1) begin n_err++; $display("FAIL spaced_combo hit=%0d got=%0d exp=1", h, combo_count); end
      for (int j = 1; j < 25; j++) begin
        tick(0, 0, 0, 0, 0);
        n_vec++; if (combo_count !== ((j >= CWIN) ? 4'd0 : 4'd1)) begin n_err++; $display("FAIL spaced_expiry j=%0d got=%0d exp=%0d", j, combo_count, (j >= CWIN) ? 0 : 1); end
      end
    end
  endtask

  task automatic test_ko();
    tick(0, 0, 0, 1, 0);
    tick(1, 190, 0, 0, 0);
    n_vec++; if (curr_health !== 9'd10) begin n_err++; $display("FAIL ko_setup got=%0d exp=10", curr_health); end
    idle(IF);
    tick(1, 255, 0, 0, 0);
    n_vec++; if (curr_health !== 9'd0) begin n_err++; $display("FAIL ko_health got=%0d exp=0", curr_health); end
    n_vec++; if ({hit_ack, ko, is_ko, stunned} !== 4'b1110) begin n_err++; $display("FAIL ko_flags got=%b exp=1110", {hit_ack, ko, is_ko, stunned}); end
    n_vec++; if (combo_count !== 4'd2) begin n_err++; $display("FAIL ko_combo got=%0d exp=2", combo_count); end
    tick(1, 40, 0, 0, 0);
    n_vec++; if ({hit_ack, ko, is_ko} !== 3'b001) begin n_err++; $display("FAIL ko_pulse got=%b exp=001", {hit_ack, ko, is_ko}); end
    for (int k = 0; k < 30; k++) tick(1, 40, k[0], 0, 0);
    n_vec++; if (curr_health !== 9'd0 || hit_ack !== 1'b0 || is_ko !== 1'b1) begin n_err++; $display("FAIL ko_hold health=%0d ack=%b is_ko=%b exp 0/0/1", curr_health, hit_ack, is_ko); end
    n_vec++; if (combo_count !== 4'd2) begin n_err++; $display("FAIL ko_combo_hold got=%0d exp=2", combo_count); end
  endtask

  task automatic test_round_start();
    tick(1, 60, 0, 1, 0);
    n_vec++; if (curr_health !== 9'd200 || hit_ack !== 1'b0) begin n_err++; $display("FAIL rs_ko health=%0d ack=%b exp 200/0", curr_health, hit_ack); end
    n_vec++; if ({ko, is_ko, stunned} !== 3'b000 || combo_count !== 4'd0) begin n_err++; $display("FAIL rs_ko_state flags=%b combo=%0d exp 000/0", {ko, is_ko, stunned}, combo_count); end
    tick(1, 20, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    n_vec++; if (stunned !== 1'b0 || curr_health !== 9'd200) begin n_err++; $display("FAIL rs_invuln stun=%b health=%0d exp 0/200", stunned, curr_health); end
    tick(1, 20, 0, 0, 0);
    n_vec++; if (hit_ack !== 1'b1 || combo_count !== 4'd1) begin n_err++; $display("FAIL rs_rehit ack=%b combo=%0d exp 1/1", hit_ack, combo_count); end
  endtask

  task automatic test_random();
    bit hv, blk, rs, rst;
    int dmg;
    for (int i = 0; i < 3000; i++) begin
      hv  = ($urandom_range(0, 2) != 0);
      dmg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      blk = $urandom_range(0, 1) != 0;
      rs  = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick(hv, dmg, blk, rs, rst);
      n_vec++; if (hit_ack !== m_ack) begin n_err++; $display("FAIL rnd_ack i=%0d got=%b exp=%b", i, hit_ack, m_ack); end
      n_vec++; if (curr_health !== 9'(m_health)) begin n_err++; $display("FAIL rnd_health i=%0d got=%0d exp=%0d", i, curr_health, m_health); end
      n_vec++; if (stunned !== exp_stun()) begin n_err++; $display("FAIL rnd_stun i=%0d got=%b exp=%b", i, stunned, exp_stun()); end
      n_vec++; if (ko !== m_kop) begin n_err++; $display("FAIL rnd_ko i=%0d got=%b exp=%b", i, ko, m_kop); end
      n_vec++; if (is_ko !== m_ko) begin n_err++; $display("FAIL rnd_is_ko i=%0d got=%b exp=%b", i, is_ko, m_ko); end
      n_vec++; if (combo_count !== 4'(exp_combo())) begin n_err++; $display("FAIL rnd_combo i=%0d got=%0d exp=%0d", i, combo_count, exp_combo()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_blocked();
    test_invuln_hold();
    test_combo_spacing();
    test_ko();
    test_round_start();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
